// File: rtl/key_udp_rx_pkg.sv
// Shared constants, header offsets and FSM state type for the UDP key-frame receiver.
// Offsets are byte indices counted from the first byte after the SFD.
package key_udp_rx_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [7:0]  BCAST_BYTE    = 8'hFF;
    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
    localparam logic [7:0]  KEY_MAGIC     = 8'hA5;

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

    localparam logic [3:0]  MAX_PREAMBLE  = 4'd7;

    localparam int          IDX_W         = 11;
    localparam logic [IDX_W-1:0] OFF_DST_MAC  = 11'd0;
    localparam logic [IDX_W-1:0] OFF_SRC_MAC  = 11'd6;
    localparam logic [IDX_W-1:0] OFF_ETH_TYPE = 11'd12;
    localparam logic [IDX_W-1:0] OFF_IP_VER   = 11'd14;
    localparam logic [IDX_W-1:0] OFF_IP_PROTO = 11'd23;
    localparam logic [IDX_W-1:0] OFF_DST_IP   = 11'd30;
    localparam logic [IDX_W-1:0] OFF_DST_PORT = 11'd36;
    localparam logic [IDX_W-1:0] OFF_MAGIC    = 11'd42;
    localparam logic [IDX_W-1:0] OFF_KEY_LO   = 11'd43;
    localparam logic [IDX_W-1:0] OFF_KEY_HI   = 11'd44;
    localparam logic [IDX_W-1:0] MIN_IDX      = 11'd49;
    localparam logic [IDX_W-1:0] MAX_IDX      = 11'd1517;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        PAYLOAD,
        DROP
    } state_t;

    // Network byte order: byte k of an nbytes-wide field, most significant first.
    function automatic logic [7:0] field_byte(input logic [47:0] field, input int nbytes, input int k);
        return 8'(field >> (8 * (nbytes - 1 - k)));
    endfunction

endpackage

// File: rtl/key_udp_rx_crc32_d8.sv
// Byte-wide reflected CRC-32 (Ethernet FCS). Clear has priority over enable.
// Running the FCS through the register leaves the fixed residue on a good frame.
module crc32_d8
    import key_udp_rx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        for (int i = 0; i < 8; i++) begin
            if (crc_d[0] ^ data[i]) begin
                crc_d = {1'b0, crc_d[31:1]} ^ CRC_POLY;
            end else begin
                crc_d = {1'b0, crc_d[31:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/key_udp_rx.sv
// GMII receiver that accepts one UDP key frame type and publishes a GBA KEYINPUT image.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | between frames; waits for the first preamble byte
// PREAMBLE | counting 0x55 bytes, waiting for the SFD
// HEADER   | idx 0..41: Ethernet/IPv4/UDP header filter
// PAYLOAD  | idx 42+: magic byte, key word, remaining payload and FCS
// DROP     | frame rejected; waits for rx_dv low, then counts one drop
module key_udp_rx
    import key_udp_rx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h00_0A_35_01_FE_C0,
    parameter logic [31:0] LOCAL_IP   = 32'hC0_A8_01_0A,
    parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic [9:0]  key_state,
    output logic        key_valid,
    output logic [15:0] good_cnt,
    output logic [15:0] drop_cnt
);

    state_t state_q, state_d;

    logic [IDX_W-1:0] idx_q;
    logic [3:0]       pre_cnt_q;
    logic             mac_local_q;
    logic             mac_bcast_q;
    logic [15:0]      cand_q;
    logic [9:0]       key_state_q;
    logic             key_valid_q;
    logic [15:0]      good_cnt_q;
    logic [15:0]      drop_cnt_q;

    logic [31:0] crc_val;
    logic        in_body;
    logic        hdr_ok;
    logic        mac_local_hit;
    logic        mac_bcast_hit;
    logic        frame_ok;
    logic        idx_inc;
    logic        pre_inc;
    logic        accept;
    logic        drop_inc;

    assign in_body  = (state_q == HEADER) || (state_q == PAYLOAD);
    assign frame_ok = (idx_q >= MIN_IDX) && (crc_val == CRC_RESIDUE);

    crc32_d8 u_crc (
        .clk   (clk),
        .reset (reset),
        .clr   (!in_body),
        .en    (in_body && rx_dv),
        .data  (rx_data),
        .crc   (crc_val)
    );

    // Destination MAC may match either the local address or broadcast; both
    // candidates are tracked byte by byte so a mix of the two is rejected.
    always_comb begin
        mac_local_hit = 1'b0;
        mac_bcast_hit = 1'b0;
        hdr_ok        = 1'b1;
        if (idx_q < OFF_SRC_MAC) begin
            mac_local_hit = mac_local_q &&
                            (rx_data == field_byte(LOCAL_MAC, 6, int'(idx_q - OFF_DST_MAC)));
            mac_bcast_hit = mac_bcast_q && (rx_data == BCAST_BYTE);
            hdr_ok        = mac_local_hit || mac_bcast_hit;
        end else if (idx_q >= OFF_ETH_TYPE && idx_q < OFF_ETH_TYPE + 11'd2) begin
            hdr_ok = rx_data == field_byte({32'h0, ETH_TYPE_IPV4}, 2, int'(idx_q - OFF_ETH_TYPE));
        end else if (idx_q == OFF_IP_VER) begin
            hdr_ok = rx_data == IP_VER_IHL;
        end else if (idx_q == OFF_IP_PROTO) begin
            hdr_ok = rx_data == IP_PROTO_UDP;
        end else if (idx_q >= OFF_DST_IP && idx_q < OFF_DST_IP + 11'd4) begin
            hdr_ok = rx_data == field_byte({16'h0, LOCAL_IP}, 4, int'(idx_q - OFF_DST_IP));
        end else if (idx_q >= OFF_DST_PORT && idx_q < OFF_DST_PORT + 11'd2) begin
            hdr_ok = rx_data == field_byte({32'h0, LOCAL_PORT}, 2, int'(idx_q - OFF_DST_PORT));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_inc  = 1'b0;
        pre_inc  = 1'b0;
        accept   = 1'b0;
        drop_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_dv) begin
                    state_d = (rx_data == PREAMBLE_BYTE) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (!rx_dv) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end else if (rx_er) begin
                    state_d = DROP;
                end else if (rx_data == PREAMBLE_BYTE) begin
                    pre_inc = pre_cnt_q <= MAX_PREAMBLE;
                end else if (rx_data == SFD_BYTE && pre_cnt_q <= MAX_PREAMBLE) begin
                    state_d = HEADER;
                end else begin
                    state_d = DROP;
                end
            end
            HEADER, PAYLOAD: begin
                if (!rx_dv) begin
                    accept   = frame_ok;
                    drop_inc = !frame_ok;
                    state_d  = IDLE;
                end else if (rx_er || idx_q > MAX_IDX) begin
                    state_d = DROP;
                end else if (state_q == HEADER) begin
                    if (!hdr_ok) begin
                        state_d = DROP;
                    end else begin
                        idx_inc = 1'b1;
                        if (idx_q == OFF_MAGIC - 11'd1) begin
                            state_d = PAYLOAD;
                        end
                    end
                end else if (idx_q == OFF_MAGIC && rx_data != KEY_MAGIC) begin
                    state_d = DROP;
                end else begin
                    idx_inc = 1'b1;
                end
            end
            DROP: begin
                if (!rx_dv) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            pre_cnt_q   <= '0;
            mac_local_q <= 1'b1;
            mac_bcast_q <= 1'b1;
            cand_q      <= '0;
            key_state_q <= 10'h3FF;
            key_valid_q <= 1'b0;
            good_cnt_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            key_valid_q <= accept;
            if (accept) begin
                key_state_q <= cand_q[9:0];
                good_cnt_q  <= good_cnt_q + 16'd1;
            end
            if (drop_inc) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end

            if (state_q == IDLE) begin
                pre_cnt_q <= 4'd1;
            end else if (pre_inc) begin
                pre_cnt_q <= pre_cnt_q + 4'd1;
            end

            if (!in_body) begin
                idx_q       <= '0;
                mac_local_q <= 1'b1;
                mac_bcast_q <= 1'b1;
            end else if (idx_inc) begin
                idx_q <= idx_q + 11'd1;
                if (idx_q < OFF_SRC_MAC) begin
                    mac_local_q <= mac_local_hit;
                    mac_bcast_q <= mac_bcast_hit;
                end
                if (idx_q == OFF_KEY_LO) begin
                    cand_q[7:0] <= rx_data;
                end
                if (idx_q == OFF_KEY_HI) begin
                    cand_q[15:8] <= rx_data;
                end
            end
        end
    end

    assign key_state = key_state_q;
    assign key_valid = key_valid_q;
    assign good_cnt  = good_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_key_udp_rx.sv
// Directed frames into key_udp_rx: header filter, FCS, rx_er, reset mid-frame, counter wrap.
module tb_key_udp_rx;

    localparam logic [47:0] MAC_L  = 48'h00_0A_35_01_FE_C0;
    localparam logic [47:0] MAC_BC = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] IP_L   = 32'hC0_A8_01_0A;
    localparam logic [15:0] PORT_L = 16'd8080;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_dv;
    logic        rx_er;
    logic [9:0]  key_state;
    logic        key_valid;
    logic [15:0] good_cnt;
    logic [15:0] drop_cnt;

    int checks   = 0;
    int failures = 0;
    int kv_cnt   = 0;
    int kv_base;

    logic [7:0] pl_q[$];
    logic [7:0] frm_q[$];

    logic [9:0]  snap_key;
    logic        snap_kv;
    logic [15:0] snap_good;
    logic [15:0] snap_drop;

    key_udp_rx dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_dv     (rx_dv),
        .rx_er     (rx_er),
        .key_state (key_state),
        .key_valid (key_valid),
        .good_cnt  (good_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_valid === 1'b1) kv_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    task automatic set_pl3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        pl_q.delete();
        pl_q.push_back(a);
        pl_q.push_back(b);
        pl_q.push_back(c);
    endtask

    task automatic build_frame(input logic [47:0] mac, input logic [31:0] ip,
                               input logic [15:0] port, input logic flip_fcs);
        logic [31:0] c;
        logic [15:0] ip_len;
        logic [15:0] udp_len;
        frm_q.delete();
        ip_len  = 16'(28 + pl_q.size());
        udp_len = 16'(8 + pl_q.size());
        for (int k = 0; k < 6; k++) frm_q.push_back(mac[47 - 8*k -: 8]);
        for (int k = 0; k < 6; k++) frm_q.push_back(8'(k * 17));
        frm_q.push_back(8'h08); frm_q.push_back(8'h00);
        frm_q.push_back(8'h45); frm_q.push_back(8'h00);
        frm_q.push_back(ip_len[15:8]); frm_q.push_back(ip_len[7:0]);
        frm_q.push_back(8'h00); frm_q.push_back(8'h01);
        frm_q.push_back(8'h40); frm_q.push_back(8'h00);
        frm_q.push_back(8'h40); frm_q.push_back(8'h11);
        frm_q.push_back(8'h00); frm_q.push_back(8'h00);
        frm_q.push_back(8'hC0); frm_q.push_back(8'hA8);
        frm_q.push_back(8'h01); frm_q.push_back(8'h02);
        for (int k = 0; k < 4; k++) frm_q.push_back(ip[31 - 8*k -: 8]);
        frm_q.push_back(8'h04); frm_q.push_back(8'hD2);
        frm_q.push_back(port[15:8]); frm_q.push_back(port[7:0]);
        frm_q.push_back(udp_len[15:8]); frm_q.push_back(udp_len[7:0]);
        frm_q.push_back(8'h00); frm_q.push_back(8'h00);
        foreach (pl_q[i]) frm_q.push_back(pl_q[i]);
        c = 32'hFFFF_FFFF;
        foreach (frm_q[i]) c = crc_upd(c, frm_q[i]);
        c = ~c;
        frm_q.push_back(c[7:0]);
        frm_q.push_back(c[15:8]);
        frm_q.push_back(c[23:16]);
        frm_q.push_back(c[31:24]);
        if (flip_fcs) frm_q[frm_q.size() - 1] = frm_q[frm_q.size() - 1] ^ 8'h10;
    endtask

    // Leaves rx_dv low on return; a following send_frame gives a one-cycle gap.
    task automatic send_frame(input int er_at, input int rst_at);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_dv   = 1'b1;
            rx_er   = 1'b0;
            rx_data = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int i = 0; i < frm_q.size(); i++) begin
            @(negedge clk);
            if (i > 0 && i - 1 == rst_at) begin
                snap_key  = key_state;
                snap_kv   = key_valid;
                snap_good = good_cnt;
                snap_drop = drop_cnt;
            end
            reset   = (i == rst_at);
            rx_er   = (i == er_at);
            rx_dv   = 1'b1;
            rx_data = frm_q[i];
        end
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_er   = 1'b0;
        reset   = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        rx_dv   = 1'b0;
        rx_er   = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_key", 32'(key_state), 32'h3FF);
        check_val("rst_kv", 32'(key_valid), 32'h0);
        check_val("rst_good", 32'(good_cnt), 32'h0);
        check_val("rst_drop", 32'(drop_cnt), 32'h0);

        // bad FCS bit
        kv_base = kv_cnt;
        set_pl3(8'hA5, 8'hF7, 8'h03);
        build_frame(MAC_L, IP_L, PORT_L, 1'b1);
        send_frame(-1, -1);
        settle();
        check_val("badfcs_key", 32'(key_state), 32'h3FF);
        check_val("badfcs_kv", 32'(kv_cnt - kv_base), 32'h0);
        check_val("badfcs_drop", 32'(drop_cnt), 32'h1);
        check_val("badfcs_good", 32'(good_cnt), 32'h0);

        // valid frame, key 0x3F7
        kv_base = kv_cnt;
        build_frame(MAC_L, IP_L, PORT_L, 1'b0);
        send_frame(-1, -1);
        settle();
        check_val("valid_key", 32'(key_state), 32'h3F7);
        check_val("valid_kv_cycles", 32'(kv_cnt - kv_base), 32'h1);
        check_val("valid_kv_low", 32'(key_valid), 32'h0);
        check_val("valid_good", 32'(good_cnt), 32'h1);
        check_val("valid_drop", 32'(drop_cnt), 32'h1);

        // broadcast to port 8081, then valid frame after a one-cycle gap
        kv_base = kv_cnt;
        set_pl3(8'hA5, 8'h5A, 8'h01);
        build_frame(MAC_BC, IP_L, 16'd8081, 1'b0);
        send_frame(-1, -1);
        build_frame(MAC_L, IP_L, PORT_L, 1'b0);
        send_frame(-1, -1);
        settle();
        check_val("gap_drop", 32'(drop_cnt), 32'h2);
        check_val("gap_good", 32'(good_cnt), 32'h2);
        check_val("gap_key", 32'(key_state), 32'h15A);
        check_val("gap_kv_cycles", 32'(kv_cnt - kv_base), 32'h1);

        // broadcast to the right port is accepted
        set_pl3(8'hA5, 8'h00, 8'h02);
        build_frame(MAC_BC, IP_L, PORT_L, 1'b0);
        send_frame(-1, -1);
        settle();
        check_val("bcast_key", 32'(key_state), 32'h200);
        check_val("bcast_good", 32'(good_cnt), 32'h3);

        // rx_er at idx20
        set_pl3(8'hA5, 8'hFF, 8'h03);
        build_frame(MAC_L, IP_L, PORT_L, 1'b0);
        send_frame(20, -1);
        settle();
        check_val("rxer_drop", 32'(drop_cnt), 32'h3);
        check_val("rxer_key", 32'(key_state), 32'h200);
        check_val("rxer_good", 32'(good_cnt), 32'h3);

        // wrong magic byte
        set_pl3(8'hA4, 8'h11, 8'h01);
        build_frame(MAC_L, IP_L, PORT_L, 1'b0);
        send_frame(-1, -1);
        settle();
        check_val("magic_drop", 32'(drop_cnt), 32'h4);
        check_val("magic_key", 32'(key_state), 32'h200);

        // only two payload bytes: idx ends at 48
        pl_q.delete();
        pl_q.push_back(8'hA5);
        pl_q.push_back(8'h11);
        build_frame(MAC_L, IP_L, PORT_L, 1'b0);
        send_frame(-1, -1);
        settle();
        check_val("short_drop", 32'(drop_cnt), 32'h5);
        check_val("short_good", 32'(good_cnt), 32'h3);

        // four payload bytes are fine
        pl_q.delete();
        pl_q.push_back(8'hA5);
        pl_q.push_back(8'h0F);
        pl_q.push_back(8'h00);
        pl_q.push_back(8'hEE);
        build_frame(MAC_L, IP_L, PORT_L, 1'b0);
        send_frame(-1, -1);
        settle();
        check_val("long_key", 32'(key_state), 32'h00F);
        check_val("long_good", 32'(good_cnt), 32'h4);

        // wrong destination IP
        set_pl3(8'hA5, 8'h01, 8'h00);
        build_frame(MAC_L, 32'hC0A8010B, PORT_L, 1'b0);
        send_frame(-1, -1);
        settle();
        check_val("ip_drop", 32'(drop_cnt), 32'h6);
        check_val("ip_key", 32'(key_state), 32'h00F);

        // reset at idx30, tail counted once as a drop
        set_pl3(8'hA5, 8'h55, 8'h01);
        build_frame(MAC_L, IP_L, PORT_L, 1'b0);
        send_frame(-1, 30);
        settle();
        check_val("midrst_key", 32'(snap_key), 32'h3FF);
        check_val("midrst_kv", 32'(snap_kv), 32'h0);
        check_val("midrst_good", 32'(snap_good), 32'h0);
        check_val("midrst_drop", 32'(snap_drop), 32'h0);
        check_val("tail_drop", 32'(drop_cnt), 32'h1);
        check_val("tail_good", 32'(good_cnt), 32'h0);
        check_val("tail_key", 32'(key_state), 32'h3FF);
        set_pl3(8'hA5, 8'hF7, 8'h03);
        build_frame(MAC_L, IP_L, PORT_L, 1'b0);
        send_frame(-1, -1);
        settle();
        check_val("postrst_key", 32'(key_state), 32'h3F7);
        check_val("postrst_good", 32'(good_cnt), 32'h1);

        // good_cnt wrap from 0xFFFF
        @(negedge clk);
        force dut.good_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.good_cnt_q;
        @(negedge clk);
        check_val("preload_good", 32'(good_cnt), 32'hFFFF);
        set_pl3(8'hA5, 8'h3C, 8'h02);
        build_frame(MAC_L, IP_L, PORT_L, 1'b0);
        send_frame(-1, -1);
        settle();
        check_val("wrap_good", 32'(good_cnt), 32'h0);
        check_val("wrap_key", 32'(key_state), 32'h23C);
        check_val("wrap_drop", 32'(drop_cnt), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
